// File: rtl/imem_banked_pkg.sv
// imem_banked_pkg: shared widths, NOP encoding, loader states and
// fetch flag bundle for the banked instruction memory.
package imem_banked_pkg;

    localparam int unsigned IMEM_PC_WIDTH    = 32;
    localparam int unsigned IMEM_INST_WIDTH  = 32;
    localparam int unsigned MEM_WIDTH        = 8;
    localparam int unsigned IMEM_LANES       = 4;
    localparam int unsigned IMEM_DEPTH_WORDS = 1024;
    localparam logic [31:0] IMEM_NOP_INST    = 32'h0000_0013;

    typedef enum logic {
        IMEM_LD_IDLE = 1'b0,
        IMEM_LD_LOAD = 1'b1
    } imem_ld_state_e;

    typedef struct packed {
        logic valid;
        logic mis;
        logic rng;
    } fetch_flags_t;

    // Fetch flag patterns for the three fetch outcomes.
    localparam fetch_flags_t FLG_NONE = '{valid: 1'b0, mis: 1'b0, rng: 1'b0};
    localparam fetch_flags_t FLG_GOOD = '{valid: 1'b1, mis: 1'b0, rng: 1'b0};
    localparam fetch_flags_t FLG_MIS  = '{valid: 1'b0, mis: 1'b1, rng: 1'b0};
    localparam fetch_flags_t FLG_RNG  = '{valid: 1'b0, mis: 1'b0, rng: 1'b1};

endpackage

// File: rtl/imem_banked_bank.sv
// imem_bank: one byte lane of the instruction memory, DEPTH x 8 bits.
// Ports: clk_i, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o async read.
module imem_bank
    import imem_banked_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH_WORDS,
    parameter int unsigned AW    = 10
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [MEM_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [MEM_WIDTH-1:0] rdata_o
);

    logic [MEM_WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_banked.sv
// imem_banked: 4-lane byte-addressed instruction memory with registered fetch,
// stall/flush hold, fault flags, byte-enable writes and streaming loader.
// Ports: fetch (fetch_req, pc, stall, flush -> inst, inst_valid, fault_*),
// direct write (wr_*), loader (ld_* in, ld_ready/ld_done/ld_err/busy out).
module imem_banked
    import imem_banked_pkg::*;
#(
    parameter int unsigned        PC_WIDTH    = IMEM_PC_WIDTH,
    parameter int unsigned        INST_WIDTH  = IMEM_INST_WIDTH,
    parameter int unsigned        DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter logic [INST_WIDTH-1:0] NOP_INST = IMEM_NOP_INST
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic                  stall,
    input  logic                  flush,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic                  fault_mis,
    output logic                  fault_rng,
    input  logic                  wr_en,
    input  logic [PC_WIDTH-1:0]   wr_addr,
    input  logic [3:0]            wr_be,
    input  logic [INST_WIDTH-1:0] wr_data,
    input  logic                  ld_start,
    input  logic [PC_WIDTH-1:0]   ld_base,
    input  logic                  ld_valid,
    input  logic [INST_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  ld_err,
    output logic                  busy
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WW = PC_WIDTH - 2;
    localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH_WORDS);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    imem_ld_state_e        state_q, state_d;
    logic [AW:0]           ld_ptr_q, ld_ptr_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    fetch_flags_t          flg_q, flg_d;
    logic                  ld_done_q, ld_done_d;
    logic                  ld_err_q, ld_err_d;

    logic pc_mis, pc_oor;
    logic wa_bad, lb_bad;
    logic in_load, beat, beat_drop;

    assign pc_mis = |pc[1:0];
    assign pc_oor = pc[PC_WIDTH-1:2] >= DEPTH_W;

    assign wa_bad = (|wr_addr[1:0]) || (wr_addr[PC_WIDTH-1:2] >= DEPTH_W);
    assign lb_bad = (|ld_base[1:0]) || (ld_base[PC_WIDTH-1:2] >= DEPTH_W);

    assign in_load = (state_q == IMEM_LD_LOAD);
    assign beat    = in_load && ld_valid;
    // Pointer parks at DEPTH_WORDS once the top word is filled; no wrap.
    assign beat_drop = beat && ld_ptr_q[AW];

    // ---------------- bank write port mux ----------------
    logic [AW-1:0]         waddr;
    logic [3:0]            wlane;
    logic [INST_WIDTH-1:0] wdata;
    logic [INST_WIDTH-1:0] rdata;

    always_comb begin
        waddr = wr_addr[AW+1:2];
        wdata = wr_data;
        wlane = 4'b0000;
        if (in_load) begin
            // Loader owns the port; direct writes are dropped.
            waddr = ld_ptr_q[AW-1:0];
            wdata = ld_data;
            if (beat && !beat_drop) begin
                wlane = 4'hF;
            end
        end else if (wr_en && !wa_bad) begin
            wlane = wr_be;
        end
    end

    for (genvar i = 0; i < IMEM_LANES; i++) begin : g_bank
        imem_bank #(
            .DEPTH (DEPTH_WORDS),
            .AW    (AW)
        ) u_bank (
            .clk_i   (clk),
            .we_i    (wlane[i]),
            .waddr_i (waddr),
            .wdata_i (wdata[8*i +: 8]),
            .raddr_i (pc[AW+1:2]),
            .rdata_o (rdata[8*i +: 8])
        );
    end

    // ---------------- fetch next state ----------------
    always_comb begin
        inst_d = inst_q;
        flg_d  = flg_q;
        if (flush) begin
            inst_d = NOP_INST;
            flg_d  = FLG_NONE;
        end else if (in_load) begin
            flg_d = FLG_NONE;
        end else if (stall) begin
            flg_d = flg_q;
        end else if (fetch_req) begin
            // Misalignment is reported in preference to range.
            if (pc_mis) begin
                inst_d = NOP_INST;
                flg_d  = FLG_MIS;
            end else if (pc_oor) begin
                inst_d = NOP_INST;
                flg_d  = FLG_RNG;
            end else begin
                inst_d = rdata;
                flg_d  = FLG_GOOD;
            end
        end else begin
            flg_d.valid = 1'b0;
        end
    end

    // ---------------- loader FSM next state ----------------
    always_comb begin
        state_d   = state_q;
        ld_ptr_d  = ld_ptr_q;
        ld_done_d = 1'b0;
        ld_err_d  = 1'b0;
        unique case (state_q)
            IMEM_LD_IDLE: begin
                if (wr_en && wa_bad) begin
                    ld_err_d = 1'b1;
                end
                if (ld_start) begin
                    if (lb_bad) begin
                        ld_err_d = 1'b1;
                    end else begin
                        state_d  = IMEM_LD_LOAD;
                        ld_ptr_d = {1'b0, ld_base[AW+1:2]};
                    end
                end
            end
            IMEM_LD_LOAD: begin
                if (wr_en) begin
                    ld_err_d = 1'b1;
                end
                if (beat) begin
                    if (beat_drop) begin
                        ld_err_d = 1'b1;
                    end else begin
                        ld_ptr_d = ld_ptr_q + PTR_ONE;
                    end
                    if (ld_last) begin
                        state_d   = IMEM_LD_IDLE;
                        ld_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IMEM_LD_IDLE;
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IMEM_LD_IDLE;
            ld_ptr_q  <= '0;
            inst_q    <= NOP_INST;
            flg_q     <= FLG_NONE;
            ld_done_q <= 1'b0;
            ld_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_ptr_q  <= ld_ptr_d;
            inst_q    <= inst_d;
            flg_q     <= flg_d;
            ld_done_q <= ld_done_d;
            ld_err_q  <= ld_err_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = flg_q.valid;
    assign fault_mis  = flg_q.mis;
    assign fault_rng  = flg_q.rng;
    assign ld_ready   = in_load;
    assign busy       = in_load;
    assign ld_done    = ld_done_q;
    assign ld_err     = ld_err_q;

endmodule

// File: tb/tb_imem_banked.sv
// tb_imem_banked: scoreboard bench for imem_banked with a byte-array
// reference model, directed scenarios and randomized traffic.
module tb_imem_banked;
    import imem_banked_pkg::*;

    localparam int D = IMEM_DEPTH_WORDS;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_req, stall, flush;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid, fault_mis, fault_rng;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_be;
    logic        ld_start, ld_valid, ld_last;
    logic [31:0] ld_base, ld_data;
    logic        ld_ready, ld_done, ld_err, busy;

    always #5 clk = ~clk;

    imem_banked dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .stall      (stall),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fault_mis  (fault_mis),
        .fault_rng  (fault_rng),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .ld_err     (ld_err),
        .busy       (busy)
    );

    typedef struct packed {
        logic        fetch_req;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        wr_en;
        logic [31:0] wr_addr;
        logic [3:0]  wr_be;
        logic [31:0] wr_data;
        logic        ld_start;
        logic [31:0] ld_base;
        logic        ld_valid;
        logic [31:0] ld_data;
        logic        ld_last;
    } stim_t;

    typedef struct packed {
        logic [31:0] inst;
        logic valid, mis, rng, rdy, done, err, busy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state.
    logic [7:0]  bytes_m [4*D];
    bit          m_load = 0;
    int unsigned m_ptr = 0;
    logic [31:0] m_inst = NOP;
    bit          m_valid = 0, m_mis = 0, m_rng = 0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [31:0] rd(int unsigned a);
        return {bytes_m[a+3], bytes_m[a+2], bytes_m[a+1], bytes_m[a]};
    endfunction

    function automatic logic [31:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 78) return 32'($urandom_range(0, D-1) * 4);
        if (r < 86) return 32'($urandom_range(0, D-1) * 4 + $urandom_range(1, 3));
        if (r < 93) return 32'(4*D + $urandom_range(0, 64) * 4);
        return 32'(4*(D - $urandom_range(1, 2)));
    endfunction

    // Computes the outputs expected after the coming clock edge.
    task automatic model(input stim_t s);
        exp_t e;
        bit done = 0;
        bit err = 0;
        if (!m_load) begin
            if (s.flush) begin
                m_inst = NOP; m_valid = 0; m_mis = 0; m_rng = 0;
            end else if (s.stall) begin
                m_valid = m_valid;
            end else if (s.fetch_req) begin
                if (s.pc % 4 != 0) begin
                    m_inst = NOP; m_valid = 0; m_mis = 1; m_rng = 0;
                end else if (s.pc / 4 >= D) begin
                    m_inst = NOP; m_valid = 0; m_mis = 0; m_rng = 1;
                end else begin
                    m_inst = rd(s.pc); m_valid = 1; m_mis = 0; m_rng = 0;
                end
            end else begin
                m_valid = 0;
            end
            if (s.wr_en) begin
                if (s.wr_addr % 4 != 0 || s.wr_addr / 4 >= D) err = 1;
                else
                    for (int i = 0; i < 4; i++)
                        if (s.wr_be[i]) bytes_m[s.wr_addr + i] = s.wr_data[8*i +: 8];
            end
            if (s.ld_start) begin
                if (s.ld_base % 4 != 0 || s.ld_base / 4 >= D) err = 1;
                else begin
                    m_load = 1;
                    m_ptr = s.ld_base / 4;
                end
            end
        end else begin
            if (s.flush) m_inst = NOP;
            m_valid = 0; m_mis = 0; m_rng = 0;
            if (s.wr_en) err = 1;
            if (s.ld_valid) begin
                if (m_ptr >= D) err = 1;
                else begin
                    for (int i = 0; i < 4; i++) bytes_m[4*m_ptr + i] = s.ld_data[8*i +: 8];
                    m_ptr++;
                end
                if (s.ld_last) begin
                    m_load = 0;
                    done = 1;
                end
            end
        end
        e.inst = m_inst; e.valid = m_valid; e.mis = m_mis; e.rng = m_rng;
        e.rdy = m_load; e.busy = m_load; e.done = done; e.err = err;
        q.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        fetch_req = s.fetch_req; pc = s.pc; stall = s.stall; flush = s.flush;
        wr_en = s.wr_en; wr_addr = s.wr_addr; wr_be = s.wr_be; wr_data = s.wr_data;
        ld_start = s.ld_start; ld_base = s.ld_base; ld_valid = s.ld_valid;
        ld_data = s.ld_data; ld_last = s.ld_last;
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        model(s);
        drive(s);
        @(posedge clk);
    endtask

    // Monitor: compares every registered output once per edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("inst", inst, e.inst);
            chk("inst_valid", inst_valid, e.valid);
            chk("fault_mis", fault_mis, e.mis);
            chk("fault_rng", fault_rng, e.rng);
            chk("ld_ready", ld_ready, e.rdy);
            chk("ld_done", ld_done, e.done);
            chk("ld_err", ld_err, e.err);
            chk("busy", busy, e.busy);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic reset_model();
        m_load = 0; m_ptr = 0; m_inst = NOP;
        m_valid = 0; m_mis = 0; m_rng = 0;
    endtask

    initial begin
        stim_t s;
        drive(idle());
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst", inst, NOP);
        chk("rst_valid", inst_valid, 0);
        chk("rst_mis", fault_mis, 0);
        chk("rst_rng", fault_rng, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_err", ld_err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        reset_model();

        // Fill the whole memory through the loader, with noise on fetch side.
        s = idle(); s.ld_start = 1; s.ld_base = 0;
        step(s);
        for (int w = 0; w < D; ) begin
            s = idle();
            s.ld_valid = ($urandom_range(0, 3) != 0);
            s.ld_data = $urandom;
            s.ld_last = s.ld_valid && (w == D-1);
            s.fetch_req = ($urandom_range(0, 1) == 1);
            s.pc = pick_addr();
            s.stall = ($urandom_range(0, 9) == 0);
            s.flush = ($urandom_range(0, 19) == 0);
            s.wr_en = ($urandom_range(0, 49) == 0);
            s.wr_addr = pick_addr(); s.wr_be = 4'hF; s.wr_data = $urandom;
            step(s);
            if (s.ld_valid) w++;
        end

        // Full-word write then fetch.
        s = idle(); s.wr_en = 1; s.wr_addr = 32'h10; s.wr_be = 4'hF; s.wr_data = 32'hDEADBEEF;
        step(s);
        s = idle(); s.fetch_req = 1; s.pc = 32'h10;
        step(s);
        #1;
        chk("t1_inst", inst, 32'hDEADBEEF);
        chk("t1_valid", inst_valid, 1);

        // Partial byte-enable write.
        s = idle(); s.wr_en = 1; s.wr_addr = 32'h20; s.wr_be = 4'hF; s.wr_data = 32'h11223344;
        step(s);
        s.wr_be = 4'b0010; s.wr_data = 32'h0000AA00;
        step(s);
        s = idle(); s.fetch_req = 1; s.pc = 32'h20;
        step(s);
        #1;
        chk("t2_inst", inst, 32'h1122AA44);

        // Fault flags.
        s = idle(); s.fetch_req = 1; s.pc = 32'h12;
        step(s);
        #1;
        chk("t3_mis", fault_mis, 1);
        chk("t3_mis_inst", inst, NOP);
        chk("t3_mis_valid", inst_valid, 0);
        s.pc = 32'(4*D);
        step(s);
        #1;
        chk("t3_rng", fault_rng, 1);
        chk("t3_rng_mis", fault_mis, 0);

        // Stall hold then flush.
        s = idle(); s.fetch_req = 1; s.pc = 32'h10;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.stall = 1; s.fetch_req = 1; s.pc = 32'h12;
            step(s);
            #1;
            chk("t4_stall_inst", inst, 32'hDEADBEEF);
            chk("t4_stall_valid", inst_valid, 1);
        end
        s = idle(); s.flush = 1; s.fetch_req = 1; s.pc = 32'h10;
        step(s);
        #1;
        chk("t4_flush_inst", inst, NOP);
        chk("t4_flush_valid", inst_valid, 0);

        // Four-beat load at 0x100.
        s = idle(); s.ld_start = 1; s.ld_base = 32'h100;
        step(s);
        for (int i = 1; i <= 4; i++) begin
            s = idle(); s.ld_valid = 1; s.ld_data = 32'(i); s.ld_last = (i == 4);
            s.fetch_req = 1; s.pc = 32'h10;
            step(s);
            #1;
            chk("t5_valid", inst_valid, 0);
            if (i < 4) chk("t5_busy", busy, 1);
            else chk("t5_done", ld_done, 1);
        end
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.fetch_req = 1; s.pc = 32'h100 + 32'(4*i);
            step(s);
            #1;
            chk("t5_fetch", inst, 32'(i + 1));
        end

        // Load past the top, then reset mid-load.
        s = idle(); s.ld_start = 1; s.ld_base = 32'(4*(D-1));
        step(s);
        s = idle(); s.ld_valid = 1; s.ld_data = 32'hCAFEF00D;
        step(s);
        s.ld_data = 32'h0BADBEEF;
        step(s);
        #1;
        chk("t6_drop_err", ld_err, 1);
        chk("t6_busy", busy, 1);
        @(negedge clk);
        drive(idle());
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", ld_ready, 0);
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(idle());
        step(idle());
        s = idle(); s.fetch_req = 1; s.pc = 32'(4*(D-1));
        step(s);
        #1;
        chk("t6_kept", inst, 32'hCAFEF00D);

        // Randomized mixed traffic.
        for (int c = 0; c < 3000; c++) begin
            s = idle();
            s.pc = pick_addr();
            s.fetch_req = ($urandom_range(0, 99) < 70);
            s.stall = ($urandom_range(0, 99) < 15);
            s.flush = ($urandom_range(0, 99) < 8);
            s.wr_addr = pick_addr();
            s.wr_be = 4'($urandom);
            s.wr_data = $urandom;
            s.ld_base = pick_addr();
            s.ld_data = $urandom;
            if (!m_load) begin
                s.wr_en = ($urandom_range(0, 99) < 20);
                s.ld_start = ($urandom_range(0, 99) < 3);
            end else begin
                s.wr_en = ($urandom_range(0, 99) < 5);
                s.ld_start = ($urandom_range(0, 99) < 5);
                s.ld_valid = ($urandom_range(0, 99) < 70);
                s.ld_last = ($urandom_range(0, 99) < 20);
            end
            step(s);
        end

        @(posedge clk);
        #2;
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
